sar_ctrl_param: RTL

//  Parametrised successor to the fixed 6-bit SAR sequencer: drives the cap-DAC switch

---
 rtl/sar_ctrl_param_pkg.sv | 16 +
 rtl/sar_bit_ptr.sv | 43 ++++
 rtl/sar_ctrl_param.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sar_ctrl_param_pkg.sv
// Shared types and helpers for the parametrised SAR sequencer.
package sar_ctrl_param_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2
  } sar_state_e;

  // Width of a counter that must hold values 0..cycles.
  function automatic int sample_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sar_bit_ptr.sv
// One-hot trial-bit pointer: load at MSB, shift toward LSB, clear.
// last_o flags that the pointer sits on bit 0 (final trial).
module sar_bit_ptr #(
  parameter int NBITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  output logic [NBITS-1:0] ptr_o,
  output logic             last_o
);

  logic [NBITS-1:0] ptr_q, ptr_d;

  // Next pointer value: clear wins over load, load wins over shift.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (load_i) begin
      ptr_d = {1'b1, {(NBITS-1){1'b0}}};
    end else if (shift_i) begin
      ptr_d = ptr_q >> 1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = ptr_q[0];

endmodule

// File: rtl/sar_ctrl_param.sv
// Parametrised SAR ADC sequencer: sample phase, NBITS bit trials driving the
// cap-DAC switch pairs, registered result with a one-cycle valid strobe.
// comp_in only feeds registers; every output decodes from flops.
module sar_ctrl_param
  import sar_ctrl_param_pkg::*;
#(
  parameter int NBITS         = 6,
  parameter int SAMPLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             abort,
  input  logic             comp_in,
  output logic             sample,
  output logic             comp_en,
  output logic [NBITS-1:0] sw,
  output logic [NBITS-1:0] sw_b,
  output logic [NBITS-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int             CNT_W    = sample_cnt_width(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic             ptr_load, ptr_shift, ptr_clear;
  logic [NBITS-1:0] trial;
  logic             last_bit;

  sar_bit_ptr #(
    .NBITS (NBITS)
  ) u_bit_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ptr_load),
    .shift_i (ptr_shift),
    .clear_i (ptr_clear),
    .ptr_o   (trial),
    .last_o  (last_bit)
  );

  // Next-state and datapath control; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    ptr_load  = 1'b0;
    ptr_shift = 1'b0;
    ptr_clear = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      code_d    = '0;
      ptr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
          end
        end
        ST_SAMPLE: begin
          code_d = '0;
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_CONVERT;
            cnt_d    = '0;
            ptr_load = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          // NOTE: blocking assignment here so result_d below sees the updated code_d.
          code_d    = code_q | (comp_in ? trial : '0);
          ptr_shift = 1'b1;
          if (last_bit) begin
            result_d  = code_d;
            valid_d   = 1'b1;
            ptr_clear = 1'b1;
            cnt_d     = '0;
            state_d   = cont_mode ? ST_SAMPLE : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter, code, result and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: result and code are real state, not storage arrays, so they take the reset.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign sample  = (state_q == ST_SAMPLE);
  assign comp_en = (state_q == ST_CONVERT);
  assign busy    = (state_q != ST_IDLE);
  assign sw      = sample ? '1 : (code_q | (comp_en ? trial : '0));
  assign sw_b    = ~sw;
  assign result  = result_q;
  assign valid   = valid_q;

endmodule
